// File: rtl/display_scan_driver_pkg.sv
// display_scan_driver_pkg: shared gate codes, display constants and hex-to-segment table
package display_scan_driver_pkg;

    typedef enum logic [2:0] {
        GATE_LOCKED  = 3'd2,
        GATE_ENTRY_A = 3'd3,
        GATE_ENTRY_B = 3'd4,
        GATE_ENTRY_C = 3'd5
    } gateStatus_e;

    localparam logic [15:0] CLOSED_PATTERN = 16'hC15D;
    localparam logic [6:0]  SEG_BLANK      = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns indexed by nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/display_scan_driver_hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low seven-segment decoder
module hex_to_7seg
    import display_scan_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: tear-free 4-digit multiplexed seven-segment scanner with edit-digit blink
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] displayElements,
    input  logic [2:0]  gateStatus,
    input  logic [1:0]  currentIndex,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] refreshCnt, refreshNext;
    logic [BW-1:0] blinkCnt, blinkNext;
    logic [1:0]    scanIdx, scanNext, prevIndex;
    logic [15:0]   snapshot, snapNext;
    logic          blinkOn, blinkOnNext, prevEdit;
    logic          refreshTc, blinkTc, editMode, restart, blank;
    logic [3:0]    nibble, anNext;
    logic [6:0]    segDecoded, segNext;

    hex_to_7seg decoder (.hex(nibble), .seg(segDecoded));

    always_comb begin
        refreshTc   = refreshCnt == RW'(REFRESH_DIV - 1);
        refreshNext = refreshTc ? '0 : refreshCnt + 1'b1;
        scanNext    = scanIdx + {1'b0, refreshTc};
        snapNext    = (refreshTc && scanIdx == 2'd3) ? displayElements : snapshot;
        editMode    = gateStatus inside {GATE_ENTRY_A, GATE_ENTRY_B, GATE_ENTRY_C};
        restart     = (currentIndex != prevIndex) || (editMode && !prevEdit);
        blinkTc     = blinkCnt == BW'(BLINK_DIV - 1);
        blinkNext   = (restart || blinkTc) ? '0 : blinkCnt + 1'b1;
        blinkOnNext = restart || (blinkOn ^ blinkTc);
        blank       = editMode && !blinkOnNext && scanNext == currentIndex;
        nibble      = 4'(snapNext >> {~scanNext, 2'b00});
        anNext      = blank ? 4'hF : ~(4'b1000 >> scanNext);
        segNext     = blank ? SEG_BLANK : segDecoded;
    end

    // Pins are driven from the post-update scan state so they never show a stale digit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refreshCnt <= '0;
            scanIdx    <= '0;
            blinkCnt   <= '0;
            blinkOn    <= 1'b1;
            snapshot   <= CLOSED_PATTERN;
            prevIndex  <= '0;
            prevEdit   <= 1'b0;
            an         <= 4'hF;
            seg        <= SEG_BLANK;
        end else begin
            refreshCnt <= refreshNext;
            scanIdx    <= scanNext;
            blinkCnt   <= blinkNext;
            blinkOn    <= blinkOnNext;
            snapshot   <= snapNext;
            prevIndex  <= currentIndex;
            prevEdit   <= editMode;
            an         <= anNext;
            seg        <= segNext;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: directed scan/tearing/blink/reset scenarios against a cycle model scoreboard
module tb_display_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] displayElements = 16'h0000;
    logic [2:0]  gateStatus = 3'd1;
    logic [1:0]  currentIndex = 2'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int failures = 0;

    int mRef, mScan, mBcnt, mPrevIdx;
    bit mBon, mPrevEdit;
    logic [15:0] mSnap;
    logic [3:0]  mAn;
    logic [6:0]  mSeg;
    logic [11:0] sb [$];

    display_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .displayElements(displayElements),
        .gateStatus(gateStatus), .currentIndex(currentIndex),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hexSeg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge();
        bit edit, restart;
        int digit;
        if (!rst_n) begin
            mRef = 0; mScan = 0; mBcnt = 0; mBon = 1; mSnap = 16'hC15D;
            mPrevIdx = 0; mPrevEdit = 0; mAn = 4'hF; mSeg = 7'h7F;
            return;
        end
        edit = gateStatus >= 3 && gateStatus <= 5;
        restart = (int'(currentIndex) != mPrevIdx) || (edit && !mPrevEdit);
        if (mRef == 3) begin
            if (mScan == 3) mSnap = displayElements;
            mScan = (mScan + 1) % 4;
            mRef = 0;
        end else mRef++;
        if (restart) begin
            mBcnt = 0; mBon = 1;
        end else if (mBcnt == 7) begin
            mBcnt = 0; mBon = !mBon;
        end else mBcnt++;
        mPrevIdx = int'(currentIndex);
        mPrevEdit = edit;
        digit = int'((mSnap >> (4 * (3 - mScan))) & 16'hF);
        if (edit && !mBon && mScan == int'(currentIndex)) begin
            mAn = 4'hF; mSeg = 7'h7F;
        end else begin
            mAn = ~(4'b1000 >> mScan); mSeg = hexSeg(digit);
        end
    endtask

    task automatic step(input string tag);
        logic [11:0] exp;
        modelEdge();
        sb.push_back({1'b1, mAn, mSeg});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check(tag, {20'd0, dp, an, seg}, {20'd0, exp});
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic waitScan(input int target, input string tag);
        for (int i = 0; i < 16 && mScan != target; i++) step(tag);
        check({tag, "_timeout"}, mScan, target);
    endtask

    task automatic waitBlinkOff(input string tag);
        for (int i = 0; i < 40 && mBon; i++) step(tag);
        check({tag, "_timeout"}, {31'd0, mBon}, 0);
    endtask

    initial begin
        run("reset", 2);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 7'h7F);
        rst_n = 1'b1;
        step("release");
        check("first_an", an, 4'b0111);
        check("first_seg", seg, 7'h46);
        run("closed", 14);

        displayElements = 16'h1234;
        run("scan", 40);

        waitScan(1, "tear_wait");
        displayElements = 16'h5678;
        run("tear", 36);

        displayElements = 16'h1234;
        run("reload", 20);
        gateStatus = 3'd3;
        currentIndex = 2'd2;
        run("blink", 48);
        gateStatus = 3'd1;
        run("noedit", 24);

        gateStatus = 3'd4;
        waitBlinkOff("off_wait");
        currentIndex = 2'd0;
        step("restart");
        check("restart_on", {31'd0, mBon}, 1);
        run("after_restart", 40);

        gateStatus = 3'd7;
        run("code7", 20);
        gateStatus = 3'd6;
        run("code6", 12);
        gateStatus = 3'd5;
        currentIndex = 2'd3;
        run("code5", 24);

        gateStatus = 3'd1;
        waitScan(2, "mid_wait");
        rst_n = 1'b0;
        step("mid_reset");
        check("mid_reset_an", an, 4'hF);
        check("mid_reset_seg", seg, 7'h7F);
        rst_n = 1'b1;
        step("mid_release");
        check("mid_first_seg", seg, 7'h46);
        run("mid_closed", 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
